// File: rtl/ttc_cmd_decoder.sv
// TTC command byte decoder: debounces GBT link-ready, splits each byte into
// single-cycle strobes, and keeps saturating event counters plus BC0 orbit checks.
module ttc_cmd_decoder #(
    parameter logic [11:0] LHC_CYCLE  = 12'd3564,
    parameter logic [3:0]  RDY_STABLE = 4'd15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        gbt_link_ready,
    input  logic [7:0]  ttc_cmd,
    input  logic        cnt_reset,
    output logic        l1a,
    output logic        bc0,
    output logic        resync,
    output logic        ec0,
    output logic        oc0,
    output logic        calpulse,
    output logic        hard_reset,
    output logic [15:0] l1a_cnt,
    output logic [15:0] bc0_cnt,
    output logic [15:0] resync_cnt,
    output logic [15:0] cmd_err_cnt,
    output logic [15:0] bc0_err_cnt,
    output logic        cmd_err,
    output logic        bc0_period_err,
    output logic        bc0_lost,
    output logic        decode_en
);

    function automatic logic [15:0] cnt_next(input logic [15:0] v, input logic inc,
                                             input logic clr);
        if (clr)
            return 16'd0;
        else if (inc && v != 16'hFFFF)
            return v + 16'd1;
        else
            return v;
    endfunction

    function automatic logic [11:0] gap_next(input logic [11:0] v);
        return (v != 12'hFFF) ? v + 12'd1 : v;
    endfunction

    logic [3:0]  rdy_cnt;
    logic [11:0] gap;
    logic        armed;

    // Stage p0: combinational decode of the byte sampled this cycle
    logic       vld_p0;
    logic [5:0] ctl_p0;
    logic       multi_p0;
    logic       ctl_ok_p0;
    logic       l1a_p0;
    logic       err_p0;
    logic       bc0_p0;
    logic       resync_p0;
    logic       perr_p0;

    assign vld_p0    = gbt_link_ready && (rdy_cnt == RDY_STABLE);
    assign ctl_p0    = ttc_cmd[6:1];
    // x & (x-1) is non-zero exactly when two or more bits are set
    assign multi_p0  = |(ctl_p0 & (ctl_p0 - 6'd1));
    assign ctl_ok_p0 = vld_p0 && !ttc_cmd[7] && !multi_p0;
    assign l1a_p0    = vld_p0 && !ttc_cmd[7] && ttc_cmd[0];
    assign err_p0    = vld_p0 && (ttc_cmd[7] || multi_p0);
    assign bc0_p0    = ctl_ok_p0 && ctl_p0[0];
    assign resync_p0 = ctl_ok_p0 && ctl_p0[1];
    assign perr_p0   = bc0_p0 && armed && (gap != LHC_CYCLE - 12'd1);

    // Stage p1: registered strobes, counters and orbit supervision
    always_ff @(posedge clock) begin
        if (reset) begin
            rdy_cnt        <= 4'd0;
            decode_en      <= 1'b0;
            l1a            <= 1'b0;
            bc0            <= 1'b0;
            resync         <= 1'b0;
            ec0            <= 1'b0;
            oc0            <= 1'b0;
            calpulse       <= 1'b0;
            hard_reset     <= 1'b0;
            cmd_err        <= 1'b0;
            bc0_period_err <= 1'b0;
            l1a_cnt        <= 16'd0;
            bc0_cnt        <= 16'd0;
            resync_cnt     <= 16'd0;
            cmd_err_cnt    <= 16'd0;
            bc0_err_cnt    <= 16'd0;
            gap            <= 12'd0;
            armed          <= 1'b0;
            bc0_lost       <= 1'b0;
        end else begin
            if (!gbt_link_ready)
                rdy_cnt <= 4'd0;
            else if (rdy_cnt != RDY_STABLE)
                rdy_cnt <= rdy_cnt + 4'd1;

            decode_en      <= vld_p0;
            l1a            <= l1a_p0;
            bc0            <= bc0_p0;
            resync         <= resync_p0;
            ec0            <= ctl_ok_p0 && ctl_p0[2];
            oc0            <= ctl_ok_p0 && ctl_p0[3];
            calpulse       <= ctl_ok_p0 && ctl_p0[4];
            hard_reset     <= ctl_ok_p0 && ctl_p0[5];
            cmd_err        <= err_p0;
            bc0_period_err <= perr_p0;

            l1a_cnt     <= cnt_next(l1a_cnt, l1a_p0, cnt_reset);
            bc0_cnt     <= cnt_next(bc0_cnt, bc0_p0, cnt_reset);
            resync_cnt  <= cnt_next(resync_cnt, resync_p0, cnt_reset);
            cmd_err_cnt <= cnt_next(cmd_err_cnt, err_p0, cnt_reset);
            bc0_err_cnt <= cnt_next(bc0_err_cnt, perr_p0, cnt_reset);

            gap <= bc0_p0 ? 12'd0 : gap_next(gap);

            if (bc0_p0)
                armed <= 1'b1;
            else if (resync_p0)
                armed <= 1'b0;

            if (bc0_p0 || resync_p0)
                bc0_lost <= 1'b0;
            else if (armed && gap >= LHC_CYCLE - 12'd1)
                bc0_lost <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ttc_cmd_decoder.sv
// Directed bench for ttc_cmd_decoder: an event-level reference model is checked
// every cycle, plus literal expectations at the interesting points.
module tb_ttc_cmd_decoder;

    localparam int LHC = 3564;
    localparam int RDY = 15;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        gbt_link_ready = 1'b0;
    logic [7:0]  ttc_cmd = 8'h00;
    logic        cnt_reset = 1'b0;
    logic        l1a, bc0, resync, ec0, oc0, calpulse, hard_reset;
    logic [15:0] l1a_cnt, bc0_cnt, resync_cnt, cmd_err_cnt, bc0_err_cnt;
    logic        cmd_err, bc0_period_err, bc0_lost, decode_en;

    ttc_cmd_decoder #(.LHC_CYCLE(12'd3564), .RDY_STABLE(4'd15)) dut (
        .clock(clock), .reset(reset), .gbt_link_ready(gbt_link_ready),
        .ttc_cmd(ttc_cmd), .cnt_reset(cnt_reset),
        .l1a(l1a), .bc0(bc0), .resync(resync), .ec0(ec0), .oc0(oc0),
        .calpulse(calpulse), .hard_reset(hard_reset),
        .l1a_cnt(l1a_cnt), .bc0_cnt(bc0_cnt), .resync_cnt(resync_cnt),
        .cmd_err_cnt(cmd_err_cnt), .bc0_err_cnt(bc0_err_cnt),
        .cmd_err(cmd_err), .bc0_period_err(bc0_period_err),
        .bc0_lost(bc0_lost), .decode_en(decode_en)
    );

    always #5 clock = ~clock;

    // Reference model: consecutive-ready run length, BC0 arrival times, event tallies
    int m_cyc = 0, m_run = 0, m_last_bc0 = 0, m_nctl = 0;
    bit m_armed = 0, m_lost = 0, m_dec = 0, m_good = 0;
    bit e_l1a, e_bc0, e_rs, e_ec0, e_oc0, e_cal, e_hr, e_err, e_perr, e_den;
    int c_l1a, c_bc0, c_rs, c_err, c_perr;

    function automatic int bump(input int c, input bit ev, input bit clr);
        if (clr) return 0;
        if (ev && c < 65535) return c + 1;
        return c;
    endfunction

    always @(posedge clock) begin
        m_cyc++;
        if (reset) begin
            m_run = 0; m_armed = 0; m_lost = 0;
            {e_l1a, e_bc0, e_rs, e_ec0, e_oc0, e_cal, e_hr, e_err, e_perr, e_den} = '0;
            c_l1a = 0; c_bc0 = 0; c_rs = 0; c_err = 0; c_perr = 0;
        end else begin
            if (!gbt_link_ready) m_run = 0;
            else if (m_run < 100) m_run++;
            m_dec  = gbt_link_ready && (m_run >= RDY + 1);
            m_nctl = $countones(ttc_cmd[6:1]);
            m_good = m_dec && !ttc_cmd[7];
            e_den  = m_dec;
            e_l1a  = m_good && ttc_cmd[0];
            e_err  = m_dec && (ttc_cmd[7] || m_nctl > 1);
            e_bc0  = m_good && m_nctl == 1 && ttc_cmd[1];
            e_rs   = m_good && m_nctl == 1 && ttc_cmd[2];
            e_ec0  = m_good && m_nctl == 1 && ttc_cmd[3];
            e_oc0  = m_good && m_nctl == 1 && ttc_cmd[4];
            e_cal  = m_good && m_nctl == 1 && ttc_cmd[5];
            e_hr   = m_good && m_nctl == 1 && ttc_cmd[6];
            e_perr = e_bc0 && m_armed && (m_cyc - m_last_bc0 != LHC);
            if (e_bc0 || e_rs) m_lost = 0;
            else if (m_armed && (m_cyc - m_last_bc0 >= LHC)) m_lost = 1;
            if (e_bc0) begin m_armed = 1; m_last_bc0 = m_cyc; end
            if (e_rs) m_armed = 0;
            c_l1a  = bump(c_l1a, e_l1a, cnt_reset);
            c_bc0  = bump(c_bc0, e_bc0, cnt_reset);
            c_rs   = bump(c_rs, e_rs, cnt_reset);
            c_err  = bump(c_err, e_err, cnt_reset);
            c_perr = bump(c_perr, e_perr, cnt_reset);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            if (errors <= 100)
                $display("FAIL %s at t=%0t got %0h want %0h", name, $time, got, want);
        end
    endtask

    task automatic compare_model();
        chk("m_l1a", l1a, e_l1a);
        chk("m_bc0", bc0, e_bc0);
        chk("m_resync", resync, e_rs);
        chk("m_ec0", ec0, e_ec0);
        chk("m_oc0", oc0, e_oc0);
        chk("m_calpulse", calpulse, e_cal);
        chk("m_hard_reset", hard_reset, e_hr);
        chk("m_cmd_err", cmd_err, e_err);
        chk("m_period_err", bc0_period_err, e_perr);
        chk("m_bc0_lost", bc0_lost, m_lost);
        chk("m_decode_en", decode_en, e_den);
        chk("m_l1a_cnt", l1a_cnt, c_l1a);
        chk("m_bc0_cnt", bc0_cnt, c_bc0);
        chk("m_resync_cnt", resync_cnt, c_rs);
        chk("m_cmd_err_cnt", cmd_err_cnt, c_err);
        chk("m_bc0_err_cnt", bc0_err_cnt, c_perr);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        compare_model();
    endtask

    // Places a BC0 (with L1A) byte 'spacing' clocks after the previous one
    task automatic bc0_at(input int spacing);
        for (int i = 0; i < spacing - 1; i++) begin
            ttc_cmd = 8'h01;
            tick();
        end
        ttc_cmd = 8'h03;
        tick();
        ttc_cmd = 8'h01;
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_l1a_cnt", l1a_cnt, 16'd0);
        chk("rst_decode_en", decode_en, 1'b0);
        chk("rst_bc0_lost", bc0_lost, 1'b0);

        // Link comes up with L1A on every byte: first strobe on the 17th cycle
        reset = 1'b0; gbt_link_ready = 1'b1; ttc_cmd = 8'h01;
        repeat (15) tick();
        chk("debounce_l1a_15", l1a, 1'b0);
        chk("debounce_en_15", decode_en, 1'b0);
        tick();
        chk("first_l1a", l1a, 1'b1);
        chk("first_l1a_cnt", l1a_cnt, 16'd1);
        chk("first_decode_en", decode_en, 1'b1);

        ttc_cmd = 8'h06; tick();
        chk("bc0rs_cmd_err", cmd_err, 1'b1);
        chk("bc0rs_no_bc0", bc0, 1'b0);
        chk("bc0rs_no_resync", resync, 1'b0);
        chk("bc0rs_err_cnt", cmd_err_cnt, 16'd1);
        ttc_cmd = 8'h81; tick();
        chk("bit7_no_l1a", l1a, 1'b0);
        chk("bit7_cmd_err", cmd_err, 1'b1);
        chk("bit7_err_cnt", cmd_err_cnt, 16'd2);
        ttc_cmd = 8'h00; tick();
        chk("cmd_err_width", cmd_err, 1'b0);

        ttc_cmd = 8'h40; tick();
        chk("hard_reset_strobe", hard_reset, 1'b1);
        chk("hard_reset_keeps_en", decode_en, 1'b1);
        ttc_cmd = 8'h09; tick();
        chk("l1a_ec0_l1a", l1a, 1'b1);
        chk("l1a_ec0_ec0", ec0, 1'b1);
        ttc_cmd = 8'h10; tick();
        ttc_cmd = 8'h20; tick();
        ttc_cmd = 8'h31; tick();
        chk("multi_keep_l1a", l1a, 1'b1);
        chk("multi_no_cal", calpulse, 1'b0);

        // One-cycle link drop restarts the debounce
        ttc_cmd = 8'h01; gbt_link_ready = 1'b0; tick();
        chk("drop_decode_en", decode_en, 1'b0);
        chk("drop_l1a", l1a, 1'b0);
        gbt_link_ready = 1'b1;
        repeat (15) tick();
        chk("redebounce_en_15", decode_en, 1'b0);
        tick();
        chk("redebounce_l1a", l1a, 1'b1);

        // Reset mid-stream discards the byte and restarts the debounce
        reset = 1'b1; tick();
        chk("midrst_l1a", l1a, 1'b0);
        chk("midrst_cnt", l1a_cnt, 16'd0);
        chk("midrst_cmd_err_cnt", cmd_err_cnt, 16'd0);
        reset = 1'b0;
        repeat (15) tick();
        chk("midrst_en_15", decode_en, 1'b0);
        tick();
        chk("midrst_l1a_16", l1a, 1'b1);

        // Orbit supervision: arm, three good orbits, then one short by a clock
        bc0_at(1);
        chk("arm_bc0", bc0, 1'b1);
        chk("arm_no_perr", bc0_period_err, 1'b0);
        for (int k = 0; k < 3; k++) begin
            bc0_at(LHC);
            chk("orbit_bc0", bc0, 1'b1);
            chk("orbit_no_perr", bc0_period_err, 1'b0);
        end
        bc0_at(LHC - 1);
        chk("short_perr", bc0_period_err, 1'b1);
        chk("short_err_cnt", bc0_err_cnt, 16'd1);
        chk("short_bc0_cnt", bc0_cnt, 16'd5);

        // BC0 stops: lost once the gap reaches a full orbit
        repeat (LHC - 1) tick();
        chk("lost_not_yet", bc0_lost, 1'b0);
        tick();
        chk("lost_set", bc0_lost, 1'b1);
        repeat (20) tick();
        chk("lost_held", bc0_lost, 1'b1);
        ttc_cmd = 8'h05; tick();
        chk("resync_strobe", resync, 1'b1);
        chk("resync_clears_lost", bc0_lost, 1'b0);
        chk("resync_cnt", resync_cnt, 16'd1);
        ttc_cmd = 8'h01;
        bc0_at(100);
        chk("rearm_bc0", bc0, 1'b1);
        chk("rearm_no_perr", bc0_period_err, 1'b0);
        chk("rearm_err_cnt", bc0_err_cnt, 16'd1);

        // Long L1A run saturates the counter; cnt_reset wins over the increment
        ttc_cmd = 8'h01;
        repeat (52000) tick();
        chk("l1a_cnt_sat", l1a_cnt, 16'hFFFF);
        tick();
        chk("l1a_cnt_sat_held", l1a_cnt, 16'hFFFF);
        cnt_reset = 1'b1; tick();
        chk("cnt_reset_l1a", l1a, 1'b1);
        chk("cnt_reset_zero", l1a_cnt, 16'd0);
        chk("cnt_reset_bc0", bc0_cnt, 16'd0);
        cnt_reset = 1'b0; tick();
        chk("after_cnt_reset", l1a_cnt, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ttc_cmd_decoder.md
TTC_CMD_DECODER -- requirements
Module: ttc_cmd_decoder

Interface
REQ-001 SHALL have parameter LHC_CYCLE, default 12'd3564, meaning clocks per orbit (expected BC0 spacing).
REQ-002 SHALL have parameter RDY_STABLE, default 4'd15, meaning consecutive link-ready samples required before decoding.
REQ-003 SHALL have port clock  input  1  40 MHz LHC clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port gbt_link_ready  input  1  GBT link locked.
REQ-006 SHALL have port ttc_cmd  input  8  one TTC command byte per clock: bit0 L1A, bit1 BC0, bit2 resync, bit3 EC0, bit4 OC0, bit5 calpulse, bit6 hard reset, bit7 reserved.
REQ-007 SHALL have port cnt_reset  input  1  clears all command counters.
REQ-008 SHALL have ports l1a, bc0, resync, ec0, oc0, calpulse, hard_reset  output  1 each  single-cycle decoded strobes; bc0 and resync drive the downstream bunch/orbit counter.
REQ-009 SHALL have ports l1a_cnt, bc0_cnt, resync_cnt, cmd_err_cnt, bc0_err_cnt  output  16 each  saturating event counters.
REQ-010 SHALL have port cmd_err  output  1  strobe, malformed command byte.
REQ-011 SHALL have port bc0_period_err  output  1  strobe, BC0 arrived at wrong spacing.
REQ-012 SHALL have port bc0_lost  output  1  level, no BC0 within one orbit.
REQ-013 SHALL have port decode_en  output  1  level, decoder accepting bytes.

Function
REQ-014 SHALL maintain 4-bit rdy_cnt: cleared when gbt_link_ready=0, incremented when 1, saturating at RDY_STABLE.
REQ-015 SHALL decode a byte only in a cycle where gbt_link_ready=1 and rdy_cnt==RDY_STABLE (first decoded byte = 16th consecutive ready cycle); decode_en SHALL be that combination, registered.
REQ-016 SHALL ignore bytes entirely (no strobes, no errors, no counts) when not decoding.
REQ-017 SHALL register all strobes: byte sampled at cycle n yields strobes at cycle n+1, width exactly one cycle.
REQ-018 SHALL pass L1A (bit0) whenever decoding and bit7=0, regardless of other bits.
REQ-019 SHALL treat bits1..6 as mutually exclusive: more than one set -> cmd_err, bits1..6 discarded, L1A still honoured.
REQ-020 SHALL treat bit7=1 as malformed: cmd_err, entire byte discarded including L1A.
REQ-021 SHALL increment 16-bit counters on the corresponding output strobe, saturating at 16'hFFFF.
REQ-022 SHALL give cnt_reset priority over increment in the same cycle (counter -> 0).
REQ-023 SHALL maintain 12-bit gap counter: 0 on the cycle after a decoded BC0, else increment, saturating at 12'hFFF.
REQ-024 SHALL set armed on first decoded BC0; resync strobe SHALL clear armed and bc0_lost.
REQ-025 SHALL flag bc0_period_err (and count) when BC0 decoded while armed and gap != LHC_CYCLE-1.
REQ-026 SHALL assert bc0_lost when armed and gap >= LHC_CYCLE-1 with no BC0 that cycle; cleared by next decoded BC0 or resync.
REQ-027 SHALL, when BC0 and resync in same byte, treat per REQ-019 (cmd_err, neither emitted).
REQ-028 SHALL NOT reset itself on hard_reset command; hard_reset is only forwarded.

Reset
REQ-029 SHALL, on reset, clear all strobes, counters, rdy_cnt, gap, armed, bc0_lost, decode_en to 0 within one clock.
REQ-030 SHALL, reset asserted mid-operation, discard the byte of that cycle and restart the ready debounce.

Verification
REQ-031 link ready rising, ttc_cmd=8'h01 every cycle -> first l1a at cycle 17 after rising edge; l1a_cnt=1 then.
REQ-032 ttc_cmd=8'h06 (BC0+resync) -> no bc0/resync strobe, cmd_err=1 one cycle, cmd_err_cnt=1; 8'h81 -> no l1a, cmd_err=1.
REQ-033 BC0 every 3564 clocks for 3 orbits, then one at 3563 spacing -> bc0_period_err once, bc0_err_cnt=1.
REQ-034 BC0 stops after armed -> bc0_lost high from gap 3563 on; resync byte -> bc0_lost 0, next BC0 no period error.
REQ-035 70000 L1As -> l1a_cnt=16'hFFFF held; cnt_reset coincident with l1a -> l1a_cnt=0.
REQ-036 gbt_link_ready drops for 1 cycle mid-stream -> bytes ignored until 16 consecutive ready cycles again, decode_en low meanwhile.
